data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Memory-side responder for the datapath's load/store port. It accepts one load or store request per transaction through a valid/ready handshake. After a fixed access latency it returns the response, with byte/halfword/word selection, sign or zero extension, and alignment and range checking. It replaces the zero-latency data memory so the core can later be made multi-cycle or stall-aware.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in storage; word index = req_address[31:2]
LATENCY, 2, wait cycles between request acceptance and response; 0 is legal

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 width/sign code
req_address  input  32  byte address
req_wdata  input  32  store data; the low byte or halfword is used for SB/SH
resp_valid  output  1  response present
resp_ready  input  1  initiator consumes the response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
  - Storage contents are not cleared.
  - An in-flight store is aborted and never committed.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE:
  - req_ready=1.
  - On req_valid=1, the request is accepted and write, funct3, address and wdata are captured.
  - If LATENCY=0, go to RESPOND. Otherwise go to WAIT with counter=LATENCY-1.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - At counter=0 the access executes and the FSM moves to RESPOND.
- Access execution:
  - Loads read the addressed word and place the result in resp_rdata.
  - Stores write the addressed word with byte enables.
  - Both happen on the edge entering RESPOND.
  - Result: resp_valid rises exactly LATENCY+1 cycles after the accept edge.
- RESPOND:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_error are held stable until resp_ready=1.
  - When resp_ready=1, on that edge: go to IDLE, resp_valid=0, resp_rdata=0, resp_error=0.
  - Back-to-back throughput is therefore one transaction per LATENCY+2 cycles.
- funct3 decode:
  - Loads: 000 LB (sign-extend byte), 001 LH (sign-extend half), 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is an error.
- Byte lanes are little-endian:
  - Byte lane = address[1:0].
  - Halfword lane = address[1].
- Errors, in priority order:
  - Illegal funct3.
  - Misaligned: halfword with address[0]=1; word with address[1:0]!=0.
  - Out of range: address[31:2] >= DEPTH_WORDS.
  - On error, no storage write occurs, resp_rdata=0 and resp_error=1. Timing is unchanged; an error still takes LATENCY+1 cycles.
- Stores return resp_rdata=0 and resp_error=0 on success.
- Input changes on req_* while not in IDLE are ignored; the captured copies are used.
- If req_valid is deasserted before acceptance, nothing happens.

Decomposition:
- Shared package constants:
  - funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_RESPOND, 2 bits).
- One sub-module: load_store_align. It is combinational and performs:
  - byte-enable generation;
  - store data lane replication;
  - load lane extraction with sign/zero extension;
  - alignment and funct3 error flags.
- The top level holds the FSM, the counter, the request registers and the storage array.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (LATENCY=2) -> resp_valid asserts 3 cycles after each accept; LW returns 0xDEADBEEF with resp_error=0.
- SB 0x11 data 0x000000A5 over word 0x12345678 at 0x10, then LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LW 0x10 -> 0x1234A578.
- LH 0x12 on word 0x80017FFF -> 0xFFFF8001; LHU 0x12 -> 0x00008001; LH 0x13 -> resp_error=1, rdata=0, storage unchanged.
- SW to 0x400 with DEPTH_WORDS=256 -> resp_error=1; a following LW 0x000 returns its prior value unchanged. Illegal funct3=011 -> resp_error=1.
- Hold resp_ready=0 for 5 cycles in RESPOND -> resp_valid, rdata and error stay stable and req_ready stays 0; request changes are ignored. resp_ready=1 -> IDLE on the next edge.
- Drive reset low during WAIT of SW 0x20 data 0x11111111 (old value 0x0) -> outputs are at reset values immediately; after release, LW 0x20 returns 0x00000000. Repeat with LATENCY=0 -> response 1 cycle after accept.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared funct3 codes, FSM state encoding and decode helper for the data memory responder.
package data_memory_responder_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ST_IDLE    = 2'b00;
   localparam logic [1:0] ST_WAIT    = 2'b01;
   localparam logic [1:0] ST_RESPOND = 2'b10;

   // Stores only have signed-width codes; the unsigned variants exist for loads alone.
   function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
      logic ok;
      case (funct3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = ~write;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_memory_responder_load_store_align.sv
// Combinational lane steering: byte enables, store replication, load extraction/extension, error flags.
module load_store_align
   import data_memory_responder_pkg::*;
(
   input  logic        i_write,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_byte_en,
   output logic [31:0] o_wdata_lanes,
   output logic [31:0] o_rdata,
   output logic        o_f3_error,
   output logic        o_align_error
);

   logic [31:0] w_shift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_shift = i_rword >> {27'd0, i_addr_lo, 3'b000};
   assign w_byte  = w_shift[7:0];
   assign w_half  = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

   // Decode access width from funct3 and steer lanes accordingly.
   always_comb begin
      o_byte_en     = 4'b0000;
      o_wdata_lanes = i_wdata;
      o_rdata       = 32'h0000_0000;
      o_f3_error    = ~f3_legal(i_write, i_funct3);
      o_align_error = 1'b0;
      case (i_funct3)
         F3_B, F3_BU: begin
            o_byte_en     = 4'b0001 << i_addr_lo;
            o_wdata_lanes = {4{i_wdata[7:0]}};
            o_rdata       = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h00_0000, w_byte};
         end
         F3_H, F3_HU: begin
            o_byte_en     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata_lanes = {2{i_wdata[15:0]}};
            o_rdata       = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
            o_align_error = i_addr_lo[0];
         end
         F3_W: begin
            o_byte_en     = 4'b1111;
            o_wdata_lanes = i_wdata;
            o_rdata       = i_rword;
            o_align_error = (i_addr_lo != 2'b00);
         end
         default: begin
            o_byte_en = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency load/store responder: valid/ready request, counted wait, held response until consumed.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_address,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int             IW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int             CW        = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0]  CNT_LOAD  = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
   localparam logic           ZERO_LAT  = (LATENCY == 0) ? 1'b1 : 1'b0;

   logic [1:0]    r_state;
   logic [CW-1:0] r_count;
   logic          r_write;
   logic [2:0]    r_funct3;
   logic [31:0]   r_address;
   logic [31:0]   r_wdata;
   logic          r_resp_valid;
   logic [31:0]   r_resp_rdata;
   logic          r_resp_error;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_idle;
   logic          w_write;
   logic [2:0]    w_funct3;
   logic [31:0]   w_address;
   logic [31:0]   w_wdata;
   logic [IW-1:0] w_word_idx;
   logic [31:0]   w_rword;
   logic [3:0]    w_byte_en;
   logic [31:0]   w_lanes;
   logic [31:0]   w_load;
   logic          w_f3_err;
   logic          w_align_err;
   logic          w_range_err;
   logic          w_err;
   logic          w_exec;
   logic          w_mem_we;
   logic [31:0]   w_rdata_next;

   // With zero latency the access runs on the accept edge, so live request fields feed the datapath in IDLE.
   assign w_idle      = (r_state == ST_IDLE);
   assign w_write     = w_idle ? req_write   : r_write;
   assign w_funct3    = w_idle ? req_funct3  : r_funct3;
   assign w_address   = w_idle ? req_address : r_address;
   assign w_wdata     = w_idle ? req_wdata   : r_wdata;
   assign w_word_idx  = w_address[IW+1:2];
   assign w_rword     = r_mem[w_word_idx];
   assign w_range_err = (w_address[31:2] >= 30'(DEPTH_WORDS));
   assign w_err       = w_f3_err | w_align_err | w_range_err;
   assign w_exec      = reset & (((r_state == ST_WAIT) && (r_count == '0)) ||
                                 (ZERO_LAT && w_idle && req_valid));
   assign w_mem_we    = w_exec & w_write & ~w_err;
   assign w_rdata_next = (w_err | w_write) ? 32'h0000_0000 : w_load;

   assign req_ready  = w_idle;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_error = r_resp_error;

   load_store_align u_align (
      .i_write       (w_write),
      .i_funct3      (w_funct3),
      .i_addr_lo     (w_address[1:0]),
      .i_wdata       (w_wdata),
      .i_rword       (w_rword),
      .o_byte_en     (w_byte_en),
      .o_wdata_lanes (w_lanes),
      .o_rdata       (w_load),
      .o_f3_error    (w_f3_err),
      .o_align_error (w_align_err)
   );

   // Storage is deliberately not reset; byte-enabled write on the edge entering RESPOND.
   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byte_en[b]) begin
               r_mem[w_word_idx][8*b +: 8] <= w_lanes[8*b +: 8];
            end
         end
      end
   end

   // Request capture, latency counter and response registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_count      <= '0;
         r_write      <= 1'b0;
         r_funct3     <= 3'b000;
         r_address    <= 32'h0000_0000;
         r_wdata      <= 32'h0000_0000;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0000_0000;
         r_resp_error <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_write   <= req_write;
                  r_funct3  <= req_funct3;
                  r_address <= req_address;
                  r_wdata   <= req_wdata;
                  if (ZERO_LAT) begin
                     r_state      <= ST_RESPOND;
                     r_resp_valid <= 1'b1;
                     r_resp_rdata <= w_rdata_next;
                     r_resp_error <= w_err;
                  end else begin
                     r_state <= ST_WAIT;
                     r_count <= CNT_LOAD;
                  end
               end
            end
            ST_WAIT: begin
               if (r_count == '0) begin
                  r_state      <= ST_RESPOND;
                  r_resp_valid <= 1'b1;
                  r_resp_rdata <= w_rdata_next;
                  r_resp_error <= w_err;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            ST_RESPOND: begin
               if (resp_ready) begin
                  r_state      <= ST_IDLE;
                  r_resp_valid <= 1'b0;
                  r_resp_rdata <= 32'h0000_0000;
                  r_resp_error <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench: two responders (LATENCY 2 and 0) checked with vector tables, corner sequences and a byte-level model.
module tb_data_memory_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_write  [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_address[2];
   logic [31:0] req_wdata  [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_error [2];

   int passed = 0;
   int total  = 0;

   logic [7:0] ref_mem [2][1024];

   typedef struct {
      logic        w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        er;
   } vec_t;

   vec_t tbl[20];
   int   nvec;

   always #5 clock = ~clock;

   data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_l2 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
      .req_funct3(req_funct3[0]), .req_address(req_address[0]), .req_wdata(req_wdata[0]),
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0])
   );

   data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_l0 (
      .clock(clock), .reset(reset),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
      .req_funct3(req_funct3[1]), .req_address(req_address[1]), .req_wdata(req_wdata[1]),
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference: memory as a byte array; access rules computed directly from width/alignment arithmetic.
   task automatic model(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int size;
      logic legal;
      logic [31:0] v;
      legal = w ? (f3 <= 3'd2) : ((f3 != 3'd3) && (f3 <= 3'd5));
      size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
      er    = !legal || ((a % size) != 0) || ((a / 4) >= 256);
      rd    = 32'h0;
      if (!er) begin
         if (w) begin
            for (int i = 0; i < size; i++) ref_mem[d][a + i] = wd[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[d][a + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8*size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
            rd = v;
         end
      end
   endtask

   task automatic txn(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
      @(negedge clock);
      check("ready_before_req", {31'd0, req_ready[d]}, 32'd1);
      req_valid[d] = 1'b1; req_write[d] = w; req_funct3[d] = f3;
      req_address[d] = a; req_wdata[d] = wd;
      @(negedge clock);
      // Scramble request fields after acceptance; the captured copy must be used.
      req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
      req_address[d] = $urandom; req_wdata[d] = $urandom;
      lat = 1;
      while (!resp_valid[d] && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      rd = resp_rdata[d];
      er = resp_error[d];
      resp_ready[d] = 1'b1;
      @(negedge clock);
      resp_ready[d] = 1'b0;
      check("release_to_idle", {30'd0, resp_valid[d], req_ready[d]}, 32'd1);
   endtask

   task automatic run_check(input int d, input string name, input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_er);
      logic [31:0] rd;
      logic er;
      int lat;
      txn(d, w, f3, a, wd, rd, er, lat);
      check({name, "_rdata"}, rd, exp_rd);
      check({name, "_error"}, {31'd0, er}, {31'd0, exp_er});
      check({name, "_latency"}, 32'(lat), 32'(lat_of(d) + 1));
   endtask

   task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd, input logic er);
      tbl[nvec] = '{w: w, f3: f3, a: a, wd: wd, rd: rd, er: er};
      nvec++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] mrd, hold_rd;
      logic mer, w;
      logic [2:0] f3;
      logic [31:0] a, wd;

      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'b000;
         req_address[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
      end
      repeat (3) @(negedge clock);
      for (int d = 0; d < 2; d++) begin
         check("reset_flags", {29'd0, resp_valid[d], req_ready[d], resp_error[d]}, 32'd2);
         check("reset_rdata", resp_rdata[d], 32'h0);
      end
      reset = 1'b1;

      // Known contents for words 0..15.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) begin
            model(d, 1'b1, 3'b010, 32'(4 * i), 32'h0, mrd, mer);
            run_check(d, "prefill", 1'b1, 3'b010, 32'(4 * i), 32'h0, 32'h0, 1'b0);
         end

      nvec = 0;
      add(1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
      add(1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
      add(1'b1, 3'b010, 32'h10,  32'h12345678, 32'h0,        1'b0);
      add(1'b1, 3'b000, 32'h11,  32'h000000A5, 32'h0,        1'b0);
      add(1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFFA5, 1'b0);
      add(1'b0, 3'b100, 32'h11,  32'h0,        32'h000000A5, 1'b0);
      add(1'b0, 3'b010, 32'h10,  32'h0,        32'h1234A578, 1'b0);
      add(1'b1, 3'b010, 32'h10,  32'h80017FFF, 32'h0,        1'b0);
      add(1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF8001, 1'b0);
      add(1'b0, 3'b101, 32'h12,  32'h0,        32'h00008001, 1'b0);
      add(1'b0, 3'b001, 32'h13,  32'h0,        32'h0,        1'b1);
      add(1'b0, 3'b010, 32'h10,  32'h0,        32'h80017FFF, 1'b0);
      add(1'b1, 3'b010, 32'h0,   32'hCAFEF00D, 32'h0,        1'b0);
      add(1'b1, 3'b010, 32'h400, 32'h01020304, 32'h0,        1'b1);
      add(1'b0, 3'b010, 32'h0,   32'h0,        32'hCAFEF00D, 1'b0);
      add(1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b1);
      add(1'b1, 3'b100, 32'h0,   32'hFFFFFFFF, 32'h0,        1'b1);
      add(1'b0, 3'b010, 32'h2,   32'h0,        32'h0,        1'b1);
      add(1'b1, 3'b001, 32'h16,  32'h0000BEEF, 32'h0,        1'b0);
      add(1'b0, 3'b010, 32'h14,  32'h0,        32'hBEEF0000, 1'b0);
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < nvec; i++) begin
            model(d, tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, mrd, mer);
            run_check(d, $sformatf("vec%0d_dut%0d", i, d), tbl[i].w, tbl[i].f3, tbl[i].a,
                      tbl[i].wd, tbl[i].rd, tbl[i].er);
         end

      // Response held while resp_ready stays low; new requests ignored.
      model(0, 1'b0, 3'b010, 32'h10, 32'h0, hold_rd, mer);
      @(negedge clock);
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_funct3[0] = 3'b010; req_address[0] = 32'h10;
      for (int i = 0; i < 20 && !resp_valid[0]; i++) @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b010;
         req_address[0] = 32'h10; req_wdata[0] = $urandom;
         @(negedge clock);
         check("hold_flags", {29'd0, resp_valid[0], req_ready[0], resp_error[0]}, 32'd4);
         check("hold_rdata", resp_rdata[0], hold_rd);
      end
      req_valid[0] = 1'b0; resp_ready[0] = 1'b1;
      @(negedge clock);
      resp_ready[0] = 1'b0;
      check("hold_release", {30'd0, resp_valid[0], req_ready[0]}, 32'd1);
      run_check(0, "hold_nowrite", 1'b0, 3'b010, 32'h10, 32'h0, hold_rd, 1'b0);

      // Reset mid-flight: store in WAIT (LATENCY 2) aborted, response (LATENCY 0) cleared.
      @(negedge clock);
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_funct3[0] = 3'b010;
      req_address[0] = 32'h20; req_wdata[0] = 32'h11111111;
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_funct3[1] = 3'b010;
      req_address[1] = 32'h10; req_wdata[1] = 32'h0;
      @(negedge clock);
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      check("rst_pre_wait", {31'd0, req_ready[0]}, 32'd0);
      check("rst_pre_resp", {31'd0, resp_valid[1]}, 32'd1);
      #1 reset = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_async_flags", {29'd0, resp_valid[d], req_ready[d], resp_error[d]}, 32'd2);
         check("rst_async_rdata", resp_rdata[d], 32'h0);
      end
      repeat (2) @(negedge clock);
      reset = 1'b1;
      run_check(0, "rst_abort", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);

      // Randomized traffic against the byte-level model.
      for (int d = 0; d < 2; d++)
         for (int n = 0; n < 150; n++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
            wd = $urandom;
            model(d, w, f3, a, wd, mrd, mer);
            run_check(d, $sformatf("rand_dut%0d", d), w, f3, a, wd, mrd, mer);
         end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
